// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
// Holds the FSM state encoding, condition codes, NZCV bit positions and field widths.
// No logic; imported by alu_cond_eval and alu_issue_ctrl.
package alu_ctrl_pkg;

   localparam int OP_W   = 4;
   localparam int COND_W = 4;
   localparam int SR_W   = 3;
   localparam int IMM_W  = 16;
   localparam int RD_W   = 4;
   localparam int FLG_W  = 4;

   // Bit positions inside the NZCV flag register
   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   // ARM condition-code encoding
   localparam logic [COND_W-1:0] COND_EQ = 4'd0;
   localparam logic [COND_W-1:0] COND_NE = 4'd1;
   localparam logic [COND_W-1:0] COND_CS = 4'd2;
   localparam logic [COND_W-1:0] COND_CC = 4'd3;
   localparam logic [COND_W-1:0] COND_MI = 4'd4;
   localparam logic [COND_W-1:0] COND_PL = 4'd5;
   localparam logic [COND_W-1:0] COND_VS = 4'd6;
   localparam logic [COND_W-1:0] COND_VC = 4'd7;
   localparam logic [COND_W-1:0] COND_HI = 4'd8;
   localparam logic [COND_W-1:0] COND_LS = 4'd9;
   localparam logic [COND_W-1:0] COND_GE = 4'd10;
   localparam logic [COND_W-1:0] COND_LT = 4'd11;
   localparam logic [COND_W-1:0] COND_GT = 4'd12;
   localparam logic [COND_W-1:0] COND_LE = 4'd13;
   localparam logic [COND_W-1:0] COND_AL = 4'd14;
   localparam logic [COND_W-1:0] COND_NV = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   // Non-operand fields of an accepted instruction
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [COND_W-1:0] cond;
      logic [SR_W-1:0]   sr;
      logic              s;
      logic [IMM_W-1:0]  imm;
      logic [RD_W-1:0]   rd;
   } issue_ctl_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Condition-code evaluator: decides whether an instruction executes given NZCV.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module alu_cond_eval
   import alu_ctrl_pkg::*;
(
   input  logic [COND_W-1:0] cond_i,
   input  logic [FLG_W-1:0]  nzcv_i,
   output logic              pass_o
);

   logic n, z, c, v;

   assign n = nzcv_i[FLG_N];
   assign z = nzcv_i[FLG_Z];
   assign c = nzcv_i[FLG_C];
   assign v = nzcv_i[FLG_V];

   // Decode the condition against the current flags
   always_comb begin
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = !z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = !c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = !n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = !v;
         COND_HI: pass_o = c & !z;
         COND_LS: pass_o = !c | z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = !z & (n == v);
         COND_LE: pass_o = z | (n != v);
         COND_AL: pass_o = 1'b1;
         default: pass_o = 1'b0;   // NV: never executes
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the simple ALU; owns NZCV, squashes failed conditions.
// Latency: accept at T, result captured and wb_valid high from T+EXEC_CYCLES.
// Backpressure: one instruction in flight; wb_ready low holds WB. Option: ALU_PERF_CNT_EN.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int EXEC_CYCLES = 1,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [OP_W-1:0]   issue_op,
   input  logic [COND_W-1:0] issue_cond,
   input  logic              issue_s,
   input  logic [SR_W-1:0]   issue_sr,
   input  logic [IMM_W-1:0]  issue_imm,
   input  logic [DATA_W-1:0] issue_a,
   input  logic [DATA_W-1:0] issue_b,
   input  logic [RD_W-1:0]   issue_rd,
   output logic [DATA_W-1:0] alu_r1,
   output logic [DATA_W-1:0] alu_r2,
   output logic [OP_W-1:0]   alu_op,
   output logic [COND_W-1:0] alu_cond,
   output logic [SR_W-1:0]   alu_sr,
   output logic              alu_s,
   output logic [IMM_W-1:0]  alu_imm,
   output logic [FLG_W-1:0]  alu_flags,
   input  logic [DATA_W:0]   alu_out,
   input  logic [FLG_W-1:0]  alu_flg,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_carry,
   output logic [FLG_W-1:0]  flags_q,
   output logic              skip_pulse,
   output logic [31:0]       exec_cnt,
   output logic [31:0]       skip_cnt
);

   if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
      $error("alu_issue_ctrl: EXEC_CYCLES must be in 1..15");
   end

   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   issue_ctl_t        ctl_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [RD_W-1:0]   wb_rd_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              wb_carry_q;
   logic              skip_q, skip_d;
   logic              accept, capture, cond_pass, in_exec;

   alu_cond_eval u_cond (
      .cond_i (issue_cond),
      .nzcv_i (flags_q),
      .pass_o (cond_pass)
   );

   // Next-state: accept in IDLE, count down the settle window, hold WB until taken
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      capture = 1'b0;
      skip_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue_valid) begin
               accept = 1'b1;
               if (cond_pass) begin
                  state_d = EXEC;
                  cnt_d   = EXEC_LOAD;
               end else begin
                  skip_d = 1'b1;
               end
            end
         end
         EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               capture = 1'b1;
               state_d = WB;
            end
         end
         WB: begin
            if (wb_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched instruction, captured result and architectural flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ctl_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_carry_q <= 1'b0;
         flags_q    <= '0;
         skip_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         skip_q  <= skip_d;
         if (accept) begin
            ctl_q <= '{op: issue_op, cond: issue_cond, sr: issue_sr, s: issue_s,
                       imm: issue_imm, rd: issue_rd};
            a_q   <= issue_a;
            b_q   <= issue_b;
         end
         if (capture) begin
            wb_rd_q    <= ctl_q.rd;
            wb_data_q  <= alu_out[DATA_W-1:0];
            wb_carry_q <= alu_out[DATA_W];
            if (ctl_q.s) flags_q <= alu_flg;
         end
      end
   end

   // The ALU is only driven while an instruction is settling
   assign in_exec     = (state_q == EXEC);
   assign alu_r1      = in_exec ? a_q        : '0;
   assign alu_r2      = in_exec ? b_q        : '0;
   assign alu_op      = in_exec ? ctl_q.op   : '0;
   assign alu_cond    = in_exec ? ctl_q.cond : '0;
   assign alu_sr      = in_exec ? ctl_q.sr   : '0;
   assign alu_s       = in_exec ? ctl_q.s    : 1'b0;
   assign alu_imm     = in_exec ? ctl_q.imm  : '0;
   assign alu_flags   = flags_q;

   assign issue_ready = (state_q == IDLE);
   assign wb_valid    = (state_q == WB);
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign wb_carry    = wb_carry_q;
   assign skip_pulse  = skip_q;

`ifdef ALU_PERF_CNT_EN
   logic [31:0] exec_cnt_q, skip_cnt_q;

   // Count completed writebacks and squashed instructions; both wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_cnt_q <= '0;
         skip_cnt_q <= '0;
      end else begin
         if (wb_valid && wb_ready) exec_cnt_q <= exec_cnt_q + 32'd1;
         if (skip_d)               skip_cnt_q <= skip_cnt_q + 32'd1;
      end
   end

   assign exec_cnt = exec_cnt_q;
   assign skip_cnt = skip_cnt_q;
`else
   assign exec_cnt = '0;
   assign skip_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1_n, rst4_n, sel4;
   logic issue_valid, issue_s, wb_ready;
   logic [3:0] issue_op, issue_cond, issue_rd, alu_flg;
   logic [2:0] issue_sr;
   logic [15:0] issue_imm;
   logic [31:0] issue_a, issue_b;
   logic [32:0] alu_out;

   // Outputs of the EXEC_CYCLES=1 instance (_1) and the EXEC_CYCLES=4 instance (_4)
   logic ir_1, ir_4, as_1, as_4, wv_1, wv_4, wc_1, wc_4, sp_1, sp_4;
   logic [31:0] r1_1, r1_4, r2_1, r2_4, wd_1, wd_4, ec_1, ec_4, sc_1, sc_4;
   logic [3:0] op_1, op_4, cd_1, cd_4, af_1, af_4, rd_1, rd_4, fq_1, fq_4;
   logic [2:0] sr_1, sr_4;
   logic [15:0] im_1, im_4;

   alu_issue_ctrl #(.EXEC_CYCLES(1), .DATA_W(32)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .issue_valid(issue_valid), .issue_ready(ir_1),
      .issue_op(issue_op), .issue_cond(issue_cond), .issue_s(issue_s), .issue_sr(issue_sr),
      .issue_imm(issue_imm), .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
      .alu_r1(r1_1), .alu_r2(r2_1), .alu_op(op_1), .alu_cond(cd_1), .alu_sr(sr_1),
      .alu_s(as_1), .alu_imm(im_1), .alu_flags(af_1), .alu_out(alu_out), .alu_flg(alu_flg),
      .wb_valid(wv_1), .wb_ready(wb_ready), .wb_rd(rd_1), .wb_data(wd_1), .wb_carry(wc_1),
      .flags_q(fq_1), .skip_pulse(sp_1), .exec_cnt(ec_1), .skip_cnt(sc_1));

   alu_issue_ctrl #(.EXEC_CYCLES(4), .DATA_W(32)) u_dut4 (
      .clk(clk), .rst_n(rst4_n), .issue_valid(issue_valid), .issue_ready(ir_4),
      .issue_op(issue_op), .issue_cond(issue_cond), .issue_s(issue_s), .issue_sr(issue_sr),
      .issue_imm(issue_imm), .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
      .alu_r1(r1_4), .alu_r2(r2_4), .alu_op(op_4), .alu_cond(cd_4), .alu_sr(sr_4),
      .alu_s(as_4), .alu_imm(im_4), .alu_flags(af_4), .alu_out(alu_out), .alu_flg(alu_flg),
      .wb_valid(wv_4), .wb_ready(wb_ready), .wb_rd(rd_4), .wb_data(wd_4), .wb_carry(wc_4),
      .flags_q(fq_4), .skip_pulse(sp_4), .exec_cnt(ec_4), .skip_cnt(sc_4));

   // Observe whichever instance is under test; the other is held in reset
   logic o_ir, o_as, o_wv, o_wc, o_sp;
   logic [31:0] o_r1, o_r2, o_wd, o_ec, o_sc;
   logic [3:0] o_op, o_cd, o_af, o_rd, o_fq;
   logic [2:0] o_sr;
   logic [15:0] o_im;
   assign o_ir = sel4 ? ir_4 : ir_1;
   assign o_as = sel4 ? as_4 : as_1;
   assign o_wv = sel4 ? wv_4 : wv_1;
   assign o_wc = sel4 ? wc_4 : wc_1;
   assign o_sp = sel4 ? sp_4 : sp_1;
   assign o_r1 = sel4 ? r1_4 : r1_1;
   assign o_r2 = sel4 ? r2_4 : r2_1;
   assign o_wd = sel4 ? wd_4 : wd_1;
   assign o_ec = sel4 ? ec_4 : ec_1;
   assign o_sc = sel4 ? sc_4 : sc_1;
   assign o_op = sel4 ? op_4 : op_1;
   assign o_cd = sel4 ? cd_4 : cd_1;
   assign o_af = sel4 ? af_4 : af_1;
   assign o_rd = sel4 ? rd_4 : rd_1;
   assign o_fq = sel4 ? fq_4 : fq_1;
   assign o_sr = sel4 ? sr_4 : sr_1;
   assign o_im = sel4 ? im_4 : im_1;

   int n_chk = 0;
   int n_pass = 0;

   // Reference state: architectural flags and expected performance counts
   logic [3:0] flags_m;
   int exec_m, skip_m;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Architectural meaning of each ARM condition, flags ordered N,Z,C,V
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [32:0] rnd33();
      return {1'($urandom), 32'($urandom)};
   endfunction

   // Noise on the issue port and the ALU stub while the controller must ignore them
   task automatic scramble();
      issue_op = 4'($urandom); issue_cond = 4'($urandom); issue_s = 1'($urandom);
      issue_sr = 3'($urandom); issue_imm = 16'($urandom); issue_a = $urandom;
      issue_b = $urandom; issue_rd = 4'($urandom);
      alu_out = rnd33(); alu_flg = 4'($urandom);
   endtask

   task automatic chk_cnt(input string tag);
`ifdef ALU_PERF_CNT_EN
      chk({tag, "_exec_cnt"}, 64'(o_ec), 64'(exec_m));
      chk({tag, "_skip_cnt"}, 64'(o_sc), 64'(skip_m));
`else
      chk({tag, "_exec_cnt"}, 64'(o_ec), 64'(0));
      chk({tag, "_skip_cnt"}, 64'(o_sc), 64'(0));
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"}, 64'(o_ir), 64'(1));
      chk({tag, "_wbv"}, 64'(o_wv), 64'(0));
      chk({tag, "_flags"}, 64'(o_fq), 64'(0));
      chk({tag, "_skip"}, 64'(o_sp), 64'(0));
      chk({tag, "_alu"}, 64'({o_r1, o_op, o_cd, o_sr, o_as, o_im}), 64'(0));
      chk({tag, "_r2"}, 64'(o_r2), 64'(0));
      chk({tag, "_wb"}, 64'({o_wd, o_rd, o_wc}), 64'(0));
      chk({tag, "_aluflags"}, 64'(o_af), 64'(0));
      chk_cnt(tag);
   endtask

   // One instruction from the idle negedge back to idle, checking every cycle
   task automatic do_insn(input int ec, input logic [3:0] c, input logic s_i,
                          input logic [3:0] flg_new, input logic [32:0] res, input int stall);
      logic [31:0] a_s, b_s;
      logic [3:0] op_s, rd_s;
      logic [2:0] sr_s;
      logic [15:0] imm_s;
      bit pass;
      chk("idle_rdy", 64'(o_ir), 64'(1));
      a_s = $urandom; b_s = $urandom; op_s = 4'($urandom); rd_s = 4'($urandom);
      sr_s = 3'($urandom); imm_s = 16'($urandom);
      issue_valid = 1'b1; issue_a = a_s; issue_b = b_s; issue_op = op_s; issue_rd = rd_s;
      issue_sr = sr_s; issue_imm = imm_s; issue_cond = c; issue_s = s_i;
      pass = cond_ok(c, flags_m);
      @(posedge clk); @(negedge clk);
      issue_valid = 1'b0;
      scramble();
      if (!pass) begin
         skip_m++;
         chk("skip_pulse", 64'(o_sp), 64'(1));
         chk("skip_rdy", 64'(o_ir), 64'(1));
         chk("skip_wbv", 64'(o_wv), 64'(0));
         chk("skip_flags", 64'(o_fq), 64'(flags_m));
         chk("skip_nodrive", 64'({o_r1, o_op}), 64'(0));
         @(posedge clk); @(negedge clk);
         chk("skip_once", 64'(o_sp), 64'(0));
         chk("skip_wbv2", 64'(o_wv), 64'(0));
         chk_cnt("skip");
         return;
      end
      for (int k = 1; k <= ec; k++) begin
         chk("exec_rdy", 64'(o_ir), 64'(0));
         chk("exec_wbv", 64'(o_wv), 64'(0));
         chk("exec_r1", 64'(o_r1), 64'(a_s));
         chk("exec_r2", 64'(o_r2), 64'(b_s));
         chk("exec_ctl", 64'({o_op, o_cd, o_sr, o_as, o_im}),
             64'({op_s, c, sr_s, s_i, imm_s}));
         chk("exec_aluflags", 64'(o_af), 64'(flags_m));
         issue_valid = 1'($urandom);
         scramble();
         wb_ready = 1'($urandom);
         if (k == ec) begin
            alu_out = res;
            alu_flg = flg_new;
         end
         @(posedge clk); @(negedge clk);
      end
      if (s_i) flags_m = flg_new;
      for (int k = 0; k <= stall; k++) begin
         chk("wb_valid", 64'(o_wv), 64'(1));
         chk("wb_data", 64'(o_wd), 64'(res[31:0]));
         chk("wb_carry", 64'(o_wc), 64'(res[32]));
         chk("wb_rd", 64'(o_rd), 64'(rd_s));
         chk("wb_flags", 64'(o_fq), 64'(flags_m));
         chk("wb_rdy", 64'(o_ir), 64'(0));
         chk("wb_nodrive", 64'(o_op), 64'(0));
         wb_ready = (k == stall);
         issue_valid = 1'($urandom);
         scramble();
         @(posedge clk); @(negedge clk);
      end
      issue_valid = 1'b0;
      wb_ready = 1'b0;
      exec_m++;
      chk("wb_drop", 64'(o_wv), 64'(0));
      chk("rdy_back", 64'(o_ir), 64'(1));
      chk("post_flags", 64'(o_fq), 64'(flags_m));
      chk_cnt("wb");
   endtask

   task automatic rand_insn(input int ec);
      do_insn(ec, 4'($urandom), 1'($urandom), 4'($urandom), rnd33(), $urandom_range(0, 3));
   endtask

   initial begin
      rst1_n = 1'b0; rst4_n = 1'b0; sel4 = 1'b0;
      issue_valid = 1'b0; wb_ready = 1'b0;
      scramble();
      flags_m = '0; exec_m = 0; skip_m = 0;

      // Phase 1: EXEC_CYCLES = 1
      repeat (2) @(negedge clk);
      chk_reset_vals("rst1");
      rst1_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst1_rel");

      do_insn(1, 4'd14, 1'b1, 4'b0000, 33'd8, 0);           // basic add-like op
      do_insn(1, 4'd14, 1'b1, 4'b0100, rnd33(), 0);         // set Z
      do_insn(1, 4'd1, 1'b1, 4'b1111, rnd33(), 0);          // NE with Z set: squashed
      do_insn(1, 4'd14, 1'b0, 4'b1111, rnd33(), 0);         // S=0 keeps flags
      do_insn(1, 4'd14, 1'b1, 4'b1111, rnd33(), 0);         // S=1 writes flags
      do_insn(1, 4'd15, 1'b1, 4'b0000, rnd33(), 0);         // NV never executes
      for (int i = 0; i < 40; i++) rand_insn(1);

      // Phase 2: EXEC_CYCLES = 4
      rst1_n = 1'b0;
      sel4 = 1'b1;
      flags_m = '0; exec_m = 0; skip_m = 0;
      @(negedge clk);
      chk_reset_vals("rst4");
      rst4_n = 1'b1;
      @(negedge clk);
      do_insn(4, 4'd14, 1'b0, 4'b0000, 33'h1_0000_0000, 0); // carry-out only
      do_insn(4, 4'd14, 1'b1, 4'b1010, rnd33(), 5);         // writeback stalled 5 cycles
      for (int i = 0; i < 30; i++) rand_insn(4);

      // Asynchronous reset while an instruction is settling
      do_insn(4, 4'd14, 1'b1, 4'b1001, 33'h0_1234_5678, 0);
      issue_valid = 1'b1; issue_cond = 4'd14; issue_s = 1'b1;
      @(posedge clk); @(negedge clk);
      issue_valid = 1'b0;
      chk("pre_rst_exec", 64'(o_ir), 64'(0));
      @(posedge clk); @(negedge clk);
      #2 rst4_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      flags_m = '0; exec_m = 0; skip_m = 0;
      @(negedge clk);
      rst4_n = 1'b1;
      wb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("midrst_nowb", 64'(o_wv), 64'(0));
      end
      wb_ready = 1'b0;
      chk_reset_vals("midrst_after");
      do_insn(4, 4'd0, 1'b1, 4'b0000, rnd33(), 0);          // EQ with cleared flags: skip
      do_insn(4, 4'd1, 1'b1, 4'b0110, rnd33(), 1);          // NE passes

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
